// File: rtl/audio_frame_pacer_if.sv
// Coding header types and the sample stream handshake between the sector
// audio decoder and the frame pacer.
package audio_frame_pacer_pkg;
    typedef enum logic {kMono = 1'b0, kStereo = 1'b1} chan_e;
    typedef enum logic {kRate378 = 1'b0, kRate189 = 1'b1} rate_e;
    typedef enum logic [1:0] {k4Bps = 2'd0, k8Bps = 2'd1, k16Bps = 2'd2} bps_e;

    typedef struct packed {
        chan_e chan;
        rate_e rate;
        bps_e  bps;
    } header_coding_s;
endpackage

interface audiostream;
    logic signed [15:0] sample;
    logic               write;
    logic               strobe;

    modport master (output sample, output write, input strobe);
    modport slave  (input sample, input write, output strobe);
    modport sink   (input sample, input write, output strobe);
endinterface

// File: rtl/audio_frame_pacer.sv
// Pairs decoded samples into stereo frames, buffers them and releases one
// frame per output-rate tick from a fractional rate accumulator.
module audio_frame_pacer
    import audio_frame_pacer_pkg::*;
#(
    parameter int CLK_HZ     = 30000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    audiostream.sink                      in,
    input  logic                          in_channel,
    input  header_coding_s                in_coding,
    input  logic                          flush,
    output logic signed [15:0]            out_left,
    output logic signed [15:0]            out_right,
    output logic                          out_valid,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ACC_W = $clog2(2 * CLK_HZ);
    localparam logic [ACC_W-1:0] CLK_V = ACC_W'(CLK_HZ);
    localparam logic [1:0] RC_378 = 2'd0;
    localparam logic [1:0] RC_189 = 2'd1;
    localparam logic [1:0] RC_441 = 2'd2;

    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
        logic [1:0]         rc;
    } frame_s;

    frame_s               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 strobe_q;
    logic signed [15:0]   last_left;
    logic [ACC_W-1:0]     acc;
    logic [1:0]           active_rc;

    logic                 fifo_full, fifo_empty, stereo, stereo_left, can_accept;
    logic                 push, pop, tick;
    logic [1:0]           in_rc;
    logic [ACC_W-1:0]     rate_v, acc_sum;
    frame_s               push_frame, head;

    always_comb begin
        fifo_full   = (count == (PTR_W+1)'(FIFO_DEPTH));
        fifo_empty  = (count == '0);
        stereo      = (in_coding.chan == kStereo);
        stereo_left = stereo & ~in_channel;
        // a stereo left only updates last_left, so it never needs FIFO space
        can_accept  = ~fifo_full | stereo_left;

        if (in_coding.bps == k16Bps)
            in_rc = RC_441;
        else if (in_coding.rate == kRate378)
            in_rc = RC_378;
        else
            in_rc = RC_189;

        push             = strobe_q & ~flush & ~stereo_left;
        push_frame.left  = stereo ? last_left : in.sample;
        push_frame.right = in.sample;
        push_frame.rc    = in_rc;

        case (active_rc)
            RC_441:  rate_v = ACC_W'(44100);
            RC_189:  rate_v = ACC_W'(18900);
            default: rate_v = ACC_W'(37800);
        endcase
        acc_sum = acc + rate_v;
        tick    = ~flush & (acc_sum >= CLK_V);
        pop     = tick & ~fifo_empty;
        head    = mem[rd_ptr];
    end

    assign in.strobe  = strobe_q;
    assign fill_level = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_left <= '0;
            acc       <= '0;
            active_rc <= RC_378;
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            // sample is consumed during the strobe cycle; write is still held then
            strobe_q <= in.write & ~strobe_q & ~flush & can_accept;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                acc    <= '0;
            end else begin
                if (strobe_q & stereo_left)
                    last_left <= in.sample;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    active_rc <= head.rc;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                acc <= tick ? (acc_sum - CLK_V) : acc_sum;
            end
            out_valid <= tick;
            underrun  <= tick & fifo_empty;
            if (pop) begin
                out_left  <= head.left;
                out_right <= head.right;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_frame;
    end
endmodule

// File: doc/audio_frame_pacer.md
Name: audio_frame_pacer

Overview:
- Sits directly downstream of the sector audio decoder.
- Accepts decoded 16-bit samples and their channel tags over the audiostream handshake, and pairs them into stereo frames; mono samples are duplicated into both channels.
- Buffers frames in a FIFO and releases one frame per output-rate tick: 37.8 kHz, 18.9 kHz or 44.1 kHz, taken from the coding tagged on each frame.
- Provides the fixed-rate L/R feed for the mixer/attenuator stage.

Parameters:
- CLK_HZ, 30000000, system clock frequency used by the fractional rate accumulator.
- FIFO_DEPTH, 16, frame entries (power of two, ≥4).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in  audiostream.sink  -  decoder sample stream:
  - in.sample[15:0] signed
  - in.write: request, held until acknowledged
  - in.strobe: one-cycle acknowledge driven by this block
- in_channel  in  1  0=left, 1=right; valid with in.write
- in_coding  in  header_coding_s  coding of the sample; valid with in.write
- flush  in  1  synchronous clear of FIFO and pairing state
- out_left  out  16  signed left sample of current frame
- out_right  out  16  signed right sample of current frame
- out_valid  out  1  one-cycle pulse per output-rate tick
- underrun  out  1  one-cycle pulse when a tick finds the FIFO empty
- fill_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored

Behaviour:
- Reset values (asynchronous, while reset=0):
  - FIFO empty, fill_level=0
  - out_left = out_right = 0; out_valid = underrun = 0; in.strobe = 0
  - rate accumulator = 0; active rate = 37.8 kHz
  - pending-left flag = 0; last-left register = 0
- Input handshake:
  - in.strobe asserts for exactly one cycle when in.write=1, in.strobe=0 on the previous cycle, and acceptance is possible.
  - Sample, channel and coding are captured in the same cycle.
  - No second strobe is issued for one write.
- Acceptance is possible when:
  - the FIFO is not full, or
  - the sample is a stereo left (channel 0 with in_coding.chan==kStereo), which completes no frame.
  - When the FIFO is full, the write stays pending and no sample is dropped.
- Pairing:
  - Mono coding: push frame {s, s}.
  - Stereo, channel 0: store s in last-left and set pending-left. A second channel-0 sample overwrites last-left.
  - Stereo, channel 1: push frame {last-left, s} and clear pending-left. A right sample with no pending left still uses the stale last-left.
- FIFO entry: 16-bit left, 16-bit right, 2-bit rate code captured from in_coding:
  - bps==k16Bps → 44100
  - else rate 37.8 → 37800
  - else 18900
- Rate generator:
  - Each cycle, accumulator += active_rate.
  - When accumulator + active_rate ≥ CLK_HZ, subtract CLK_HZ and raise a tick.
  - Accumulator width: $clog2(2*CLK_HZ) bits.
  - active_rate updates to the rate code of each popped frame, effective from the next cycle.
  - While the FIFO has been empty since reset or flush, active_rate holds its last value.
- On tick:
  - FIFO non-empty: pop; out_left/out_right take the popped frame the same cycle out_valid pulses (registered, 1-cycle latency from tick).
  - FIFO empty: out_left/out_right hold their previous values, out_valid still pulses, underrun pulses.
- Simultaneous push and pop in one cycle: both occur, fill_level unchanged. A push into a full FIFO is impossible by the handshake rule.
- flush:
  - Next cycle: FIFO empty, pending-left cleared, accumulator cleared.
  - Outputs hold their current values.
  - A write that is in progress is neither acknowledged nor lost; it is accepted after flush.
- Reset mid-frame discards pending-left and all buffered frames.

Test Plan:
- Mono 18.9 kHz, CLK_HZ=30e6; push samples 0x0100, 0x0200, 0x0300 → three frames {0x0100,0x0100}, {0x0200,0x0200}, {0x0300,0x0300}; out_valid spacing 1587/1588 cycles; 18900 pulses per 30e6 cycles ±1.
- Stereo 37.8 kHz; push L=0x1111, R=0x2222, L=0x3333, R=0x4444 → frames {0x1111,0x2222}, {0x3333,0x4444}; each strobe is a single-cycle pulse; fill_level peaks at 2.
- Fill FIFO to 16 frames, then assert in.write → in.strobe stays 0 until the next tick pops a frame; strobe follows within 2 cycles; no sample lost; fill_level returns to 16.
- Empty FIFO at a tick → out_valid=1, underrun=1, outputs hold the last frame {0x3333,0x4444}.
- Queue two 37.8 kHz frames then one 44.1 kHz CDDA frame → tick spacing changes from ~794 to ~680 cycles after the CDDA frame pops.
- Assert flush with 5 frames queued and a pending left → fill_level=0 next cycle, no out_valid with new data. Also drive reset low mid-stream → all outputs 0 immediately.
